// File: rtl/filter_out_buffer.sv
// Output stage of the filter: optional decimation, then a fall-through FIFO
// toward a valid/ready sink, with a sticky flag for samples lost on full.
module filter_out_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DECIM  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [CW-1:0]     r_dcnt;
  logic              r_ovf;

  logic w_keep;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A kept sample still enters a full FIFO when the head leaves on the same edge.
  assign w_keep = in_valid && (r_dcnt == '0);
  assign w_full = (r_level == LW'(DEPTH));
  assign w_pop  = (r_level != '0) && out_ready;
  assign w_push = w_keep && (!w_full || w_pop);
  assign w_drop = w_keep && w_full && !w_pop;

  // Decimation counter advances on every strobe, kept or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dcnt <= '0;
    end else if (in_valid) begin
      if (r_dcnt == CW'(DECIM - 1)) begin
        r_dcnt <= '0;
      end else begin
        r_dcnt <= CW'(r_dcnt + CW'(1));
      end
    end
  end

  // Sample storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= AW'(r_wr_ptr + AW'(1));
      end
      if (w_pop) begin
        r_rd_ptr <= AW'(r_rd_ptr + AW'(1));
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= LW'(r_level + LW'(1));
        2'b01:   r_level <= LW'(r_level - LW'(1));
        default: r_level <= r_level;
      endcase
    end
  end

  // Set beats clear when both happen on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign out_valid = (r_level != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign level     = r_level;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_filter_out_buffer.sv
// Directed bench for filter_out_buffer: one instance without decimation, one with DECIM=3.
module tb_filter_out_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, clr_ovf;
  logic [7:0] in_data;
  logic       out_valid, overflow;
  logic [7:0] out_data;
  logic [4:0] level;

  logic       in_valid3, out_ready3, clr_ovf3;
  logic [7:0] in_data3;
  logic       out_valid3, overflow3;
  logic [7:0] out_data3;
  logic [4:0] level3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  filter_out_buffer #(.DATA_W(8), .DEPTH(16), .DECIM(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  filter_out_buffer #(.DATA_W(8), .DEPTH(16), .DECIM(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_data(in_data3),
    .out_ready(out_ready3), .out_valid(out_valid3), .out_data(out_data3),
    .level(level3), .overflow(overflow3), .clr_ovf(clr_ovf3)
  );

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    int         el;
    logic       eo;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] base);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(base + 8'(i));
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 8'h05, 1, 1'b0};
    tbl[1] = '{1'b1, 8'hFB, 1'b1, 1'b0, 1'b1, 8'hFB, 1, 1'b0};
    tbl[2] = '{1'b1, 8'h7F, 1'b1, 1'b0, 1'b1, 8'h7F, 1, 1'b0};
    tbl[3] = '{1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 1, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    tbl[6] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h33, 1, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33, 1, 1'b0};
    tbl[8] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h44, 1, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0; clr_ovf3 = 1'b0;

    // Reset and idle
    repeat (3) step();
    rst_n = 1'b1;
    step();
    step();
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_level", int'(level), 0);
    chk("reset_ovf", int'(overflow), 0);
    chk("reset_level3", int'(level3), 0);

    // Table-driven pass-through and simple handshake cases
    for (int i = 0; i < 10; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      out_ready = tbl[i].rdy;
      clr_ovf   = tbl[i].clr;
      step();
      chk($sformatf("vec%0d_valid", i), int'(out_valid), int'(tbl[i].ev));
      chk($sformatf("vec%0d_level", i), int'(level), tbl[i].el);
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(tbl[i].eo));
      if (tbl[i].ev) chk($sformatf("vec%0d_data", i), int'(out_data), int'(tbl[i].ed));
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // Fill with 0..16; 16 is dropped
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
      chk($sformatf("fill%0d_level", i), int'(level), (i < 16) ? i + 1 : 16);
      chk($sformatf("fill%0d_ovf", i), int'(overflow), (i < 16) ? 0 : 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d_valid", k), int'(out_valid), 1);
      chk($sformatf("drain%0d_data", k), int'(out_data), k);
      step();
    end
    chk("drain_level", int'(level), 0);
    chk("drain_valid", int'(out_valid), 0);
    chk("drain_ovf_sticky", int'(overflow), 1);
    out_ready = 1'b0;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", int'(overflow), 0);

    // Full with simultaneous push and pop
    fill(8'h20);
    chk("full_level", int'(level), 16);
    in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pushpop_level", int'(level), 16);
    chk("pushpop_ovf", int'(overflow), 0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("pp_drain%0d", k), int'(out_data), (k < 15) ? 8'h21 + k : 8'hAA);
      step();
    end
    chk("pp_empty", int'(out_valid), 0);
    out_ready = 1'b0;

    // Overflow set and clear on the same edge: set wins
    fill(8'h40);
    in_valid = 1'b1; in_data = 8'hEE; clr_ovf = 1'b1;
    step();
    in_valid = 1'b0;
    chk("collide_ovf", int'(overflow), 1);
    chk("collide_level", int'(level), 16);
    step();
    clr_ovf = 1'b0;
    chk("clr_after_collide", int'(overflow), 0);
    chk("head_after_collide", int'(out_data), 8'h40);

    // Asynchronous reset mid-cycle while full with overflow set
    in_valid = 1'b1; in_data = 8'h99;
    step();
    in_valid = 1'b0;
    chk("pre_async_ovf", int'(overflow), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_level", int'(level), 0);
    chk("async_valid", int'(out_valid), 0);
    chk("async_ovf", int'(overflow), 0);
    step();
    #2;
    rst_n = 1'b1;
    step();

    // Decimation by 3: strobes 10..18 keep 10, 13, 16
    out_ready3 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid3 = 1'b1;
      in_data3  = 8'(10 + i);
      step();
      chk($sformatf("dec%0d_level", i), int'(level3), i / 3 + 1);
    end
    in_valid3  = 1'b0;
    out_ready3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dec_drain%0d", k), int'(out_data3), 10 + 3 * k);
      step();
    end
    chk("dec_empty", int'(out_valid3), 0);
    out_ready3 = 1'b0;

    // Reset with a partial decimation count: first strobe after release is kept
    in_valid3 = 1'b1; in_data3 = 8'h11;
    step();
    in_valid3 = 1'b0;
    chk("dec_partial_level", int'(level3), 1);
    #2;
    rst_n = 1'b0;
    step();
    #2;
    rst_n = 1'b1;
    step();
    in_valid3 = 1'b1; in_data3 = 8'h55;
    step();
    in_valid3 = 1'b0;
    chk("dec_post_reset_level", int'(level3), 1);
    chk("dec_post_reset_data", int'(out_data3), 8'h55);
    in_valid3 = 1'b1; in_data3 = 8'h66;
    step();
    in_valid3 = 1'b0;
    chk("dec_post_reset_skip", int'(level3), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/filter_out_buffer.md
Name: filter_out_buffer

Overview:
- Downstream stage of the filter: captures each filtered sample the filter presents on its done strobe.
- Optionally decimates the samples, then buffers them in a small FIFO.
- Presents them to the sink (file writer / DAC interface) through a valid/ready handshake.
- Decouples the filter's fixed sample rate from a sink that may stall, and flags lost samples.

Parameters:
- DATA_W, 8, width of filter output sample (signed two's complement, passed through unmodified)
- DEPTH, 16, FIFO entries; power of two, 2..256
- DECIM, 1, keep one of every DECIM accepted samples; 1 = no decimation, range 1..255

Ports:
- clk  input  1  single system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  one-cycle strobe from filter done; in_data valid this cycle
- in_data  input  DATA_W  filter dataout sample
- out_ready  input  1  sink can accept head sample this cycle
- out_valid  output  1  FIFO non-empty; out_data holds head sample
- out_data  output  DATA_W  head-of-FIFO sample
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
- overflow  output  1  sticky: a kept sample was dropped because FIFO was full
- clr_ovf  input  1  synchronous clear of overflow

Behaviour:
- Reset:
  - Asserting rst_n low clears, immediately and asynchronously: write/read pointers, level=0, out_valid=0, decimation counter=0, overflow=0.
  - Memory contents are not reset. out_data is X-tolerant while out_valid=0; the bench must not check it then.
  - Reset mid-operation discards all buffered samples. The first in_valid after release is kept (counter=0).
- Decimation:
  - dcnt counts 0..DECIM-1 and advances on every in_valid, wrapping DECIM-1 -> 0.
  - A sample is "kept" when in_valid=1 and dcnt==0. Others are ignored and do not touch the FIFO.
  - dcnt advances even when the kept sample is dropped for full.
- Push: kept sample and (level<DEPTH, or a pop happens in the same cycle). Sample written at wr_ptr, wr_ptr+1 mod DEPTH.
- Pop: out_valid=1 and out_ready=1. rd_ptr+1 mod DEPTH.
- Level update per edge:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- Full and kept sample with no pop:
  - Sample dropped; pointers and level unchanged.
  - overflow set to 1 on that edge.
- Full with simultaneous pop: push accepted, level stays DEPTH, no overflow.
- Empty: out_ready ignored; no pointer movement; level never underflows.
- Outputs:
  - out_valid = (level != 0), derived from registered level.
  - out_data = mem[rd_ptr] (registered memory, combinational read).
  - Latency: sample on in_valid in cycle N is visible on out_valid/out_data in cycle N+1. Fall-through; no extra pipeline stage.
- overflow clear: clr_ovf=1 clears it on the next edge. If an overflow event and clr_ovf coincide, set wins (overflow=1).
- Ordering: strict FIFO; data bits pass unaltered (no sign change, no saturation).
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy comes only from level, never from pointer compare.

Test Plan:
- Reset/idle: hold rst_n=0 3 cycles, release, no in_valid -> out_valid=0, level=0, overflow=0. Assert rst_n low asynchronously mid-cycle -> outputs clear before next edge.
- Pass-through (DECIM=1, out_ready=1):
  - Stimulus: in_valid strobes with in_data 8'h05, 8'hFB(-5), 8'h7F, 8'h80.
  - Expected: each appears on out_data the cycle after its strobe, same order, bit-exact; level never exceeds 1.
- Fill and overflow (DEPTH=16, out_ready=0):
  - Stimulus: push 17 samples 0..16.
  - Expected: level=16; overflow=1 after the 17th; value 16 is absent.
  - Then out_ready=1: drains 0..15 in order, level returns to 0, overflow still 1. clr_ovf pulse -> overflow=0.
- Full with simultaneous push/pop: at level=16, assert in_valid and out_ready in the same cycle -> level stays 16, overflow stays 0, new sample exits 16th after the popped one.
- Decimation (DECIM=3): 9 strobes carrying 10..18 -> only 10, 13, 16 appear on out_data; level peaks at 3 with out_ready=0.
- Overflow set/clear collision: full FIFO, kept sample and clr_ovf in the same cycle -> overflow=1 after the edge. The next cycle, clr_ovf alone -> overflow=0.
